i2s_xmit: RTL and testbench

//  I2S transmitter: output stage of the pedal audio path, driving the DAC serial data line.

---
 rtl/i2s_xmit.sv | 164 ++++++++++++++++
 tb/tb_i2s_xmit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_xmit.sv
`default_nettype none
// ============================================================================
// Module   : i2s_xmit
// Purpose  : I2S transmitter for the pedal audio output path. It takes 24-bit
//            stereo pairs through a one-entry valid/ready buffer and shifts
//            them out MSB-first on sdout. Framing comes from the bck/lrck pair
//            made by clk_div, and everything runs in the mck domain.
//            Optional feature: define I2S_XMIT_UNDERRUN_CNT_EN to add the
//            saturating underrun_cnt[7:0] output.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_xmit #(
   parameter int DATA_W        = 24,
   parameter int SLOT_W        = 32,
   parameter int UNDERRUN_HOLD = 0
) (
   input  logic              mck,
   input  logic              reset,
   input  logic              bck,
   input  logic              lrck,
   input  logic [DATA_W-1:0] in_left,
   input  logic [DATA_W-1:0] in_right,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              sdout,
   output logic              frame_start,
   output logic              underrun
`ifdef I2S_XMIT_UNDERRUN_CNT_EN
   ,
   output logic [7:0]        underrun_cnt
`endif
);

   localparam int                 c_IDX_W     = $clog2(SLOT_W);
   localparam logic [c_IDX_W-1:0] c_IDX_MAX   = c_IDX_W'(SLOT_W - 1);
   localparam logic [c_IDX_W-1:0] c_DATA_LAST = c_IDX_W'(DATA_W);

   logic               r_bck_q;
   logic               r_lrck_q;
   logic               r_buf_full;
   logic               r_armed;
   logic [DATA_W-1:0]  r_buf_l;
   logic [DATA_W-1:0]  r_buf_r;
   logic [DATA_W-1:0]  r_sh_l;
   logic [DATA_W-1:0]  r_sh_r;
   logic [DATA_W-1:0]  r_last_l;
   logic [DATA_W-1:0]  r_last_r;
   logic [c_IDX_W-1:0] r_bit_idx;

   logic               w_bck_fall;
   logic               w_lrck_fall;
   logic               w_lrck_edge;
   logic               w_accept;
   logic               w_underrun_evt;
   logic               w_in_data;
   logic [c_IDX_W-1:0] w_idx_next;

   assign w_bck_fall     = r_bck_q & ~bck;
   assign w_lrck_fall    = r_lrck_q & ~lrck;
   assign w_lrck_edge    = r_lrck_q ^ lrck;
   assign in_ready       = ~r_buf_full;
   assign w_accept       = in_valid & ~r_buf_full;
   assign w_underrun_evt = w_lrck_fall & ~r_buf_full & r_armed;

   // Bit index within the half-frame: lrck edges realign, bck falls advance (saturating).
   always_comb begin
      w_idx_next = r_bit_idx;
      if (w_lrck_edge) begin
         w_idx_next = '0;
      end else if (w_bck_fall && (r_bit_idx != c_IDX_MAX)) begin
         w_idx_next = r_bit_idx + 1'b1;
      end
      // Slot 0 is the I2S one-bit delay; data occupies slots 1..DATA_W.
      w_in_data = (w_idx_next != '0) && (w_idx_next <= c_DATA_LAST);
   end

   // Register the frame clocks once so edges are seen as input vs. previous value.
   always_ff @(posedge mck or negedge reset) begin
      if (!reset) begin
         r_bck_q   <= 1'b0;
         r_lrck_q  <= 1'b0;
         r_bit_idx <= '0;
      end else begin
         r_bck_q   <= bck;
         r_lrck_q  <= lrck;
         r_bit_idx <= w_idx_next;
      end
   end

   // Input buffer: capture on handshake, release to the shifters at frame start.
   always_ff @(posedge mck or negedge reset) begin
      if (!reset) begin
         r_buf_full <= 1'b0;
         r_buf_l    <= '0;
         r_buf_r    <= '0;
      end else begin
         if (w_lrck_fall && r_buf_full) begin
            r_buf_full <= 1'b0;
         end
         if (w_accept) begin
            r_buf_full <= 1'b1;
            r_buf_l    <= in_left;
            r_buf_r    <= in_right;
         end
      end
   end

   // Frame start loads the shifters (new pair, held pair or silence); bck falls shift them.
   always_ff @(posedge mck or negedge reset) begin
      if (!reset) begin
         r_armed  <= 1'b0;
         r_sh_l   <= '0;
         r_sh_r   <= '0;
         r_last_l <= '0;
         r_last_r <= '0;
      end else if (w_lrck_fall) begin
         r_armed <= 1'b1;
         if (r_buf_full) begin
            r_sh_l   <= r_buf_l;
            r_sh_r   <= r_buf_r;
            r_last_l <= r_buf_l;
            r_last_r <= r_buf_r;
         end else begin
            // Before the first armed frame the last-pair regs are still zero.
            r_sh_l <= (UNDERRUN_HOLD != 0) ? r_last_l : '0;
            r_sh_r <= (UNDERRUN_HOLD != 0) ? r_last_r : '0;
         end
      end else if (w_bck_fall && w_in_data) begin
         if (r_lrck_q) begin
            r_sh_r <= {r_sh_r[DATA_W-2:0], 1'b0};
         end else begin
            r_sh_l <= {r_sh_l[DATA_W-2:0], 1'b0};
         end
      end
   end

   // Serial output and status pulses, updated on bck falls / frame start.
   always_ff @(posedge mck or negedge reset) begin
      if (!reset) begin
         sdout       <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= w_lrck_fall;
         underrun    <= w_underrun_evt;
         if (w_bck_fall) begin
            sdout <= w_in_data & (r_lrck_q ? r_sh_r[DATA_W-1] : r_sh_l[DATA_W-1]);
         end
      end
   end

`ifdef I2S_XMIT_UNDERRUN_CNT_EN
   // Saturating count of underrun frames since reset.
   always_ff @(posedge mck or negedge reset) begin
      if (!reset) begin
         underrun_cnt <= 8'h00;
      end else if (w_underrun_evt && (underrun_cnt != 8'hFF)) begin
         underrun_cnt <= underrun_cnt + 8'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_xmit.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_xmit
// Purpose  : Self-checking bench for i2s_xmit. It runs one instance with
//            UNDERRUN_HOLD=0 and one with UNDERRUN_HOLD=1 in parallel, and
//            checks both against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_xmit;

   localparam int DATA_W = 24;
   localparam int FRAME  = 128;   // mck per frame: bck = mck/2, 64 bck per frame

   logic              mck = 1'b0;
   logic              reset = 1'b0;
   logic              bck = 1'b0;
   logic              lrck = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_left = '0;
   logic [DATA_W-1:0] in_right = '0;
   logic              in_ready [2];
   logic              sdout [2];
   logic              frame_start [2];
   logic              underrun [2];
`ifdef I2S_XMIT_UNDERRUN_CNT_EN
   logic [7:0]        ucnt [2];
`endif

   int n_cmp = 0;
   int n_err = 0;
   int cnt = 0;
   int ur_seen = 0;

   // reference model state
   bit                m_full, m_armed, m_fs, m_ur, m_acc;
   bit                m_prev_rst = 1'b1;
   bit                m_sd [2];
   logic [DATA_W-1:0] m_buf_l, m_buf_r;
   logic [DATA_W-1:0] m_tx_l [2];
   logic [DATA_W-1:0] m_tx_r [2];
   int                m_ucnt;

   always #5 mck = ~mck;

   i2s_xmit #(.DATA_W(DATA_W), .SLOT_W(32), .UNDERRUN_HOLD(0)) dut0 (
      .mck(mck), .reset(reset), .bck(bck), .lrck(lrck),
      .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
      .in_ready(in_ready[0]), .sdout(sdout[0]),
      .frame_start(frame_start[0]), .underrun(underrun[0])
`ifdef I2S_XMIT_UNDERRUN_CNT_EN
      , .underrun_cnt(ucnt[0])
`endif
   );

   i2s_xmit #(.DATA_W(DATA_W), .SLOT_W(32), .UNDERRUN_HOLD(1)) dut1 (
      .mck(mck), .reset(reset), .bck(bck), .lrck(lrck),
      .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
      .in_ready(in_ready[1]), .sdout(sdout[1]),
      .frame_start(frame_start[1]), .underrun(underrun[1])
`ifdef I2S_XMIT_UNDERRUN_CNT_EN
      , .underrun_cnt(ucnt[1])
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame-level model: what each bit slot must carry, and what happens at frame start.
   task automatic model_step();
      int c, n;
      bit fs, right, acc;
      c     = cnt;
      m_acc = 1'b0;
      if (!reset) begin
         m_full = 0; m_armed = 0; m_fs = 0; m_ur = 0; m_ucnt = 0;
         for (int i = 0; i < 2; i++) begin
            m_tx_l[i] = '0; m_tx_r[i] = '0; m_sd[i] = 1'b0;
         end
         m_prev_rst = 1'b1;
         return;
      end
      fs = (c % FRAME == 0) && !m_prev_rst;
      if (c % 2 == 0) begin
         n     = (c % 64) / 2;
         right = (c % FRAME) >= 64;
         for (int i = 0; i < 2; i++) begin
            if (n >= 1 && n <= DATA_W)
               m_sd[i] = right ? m_tx_r[i][DATA_W-n] : m_tx_l[i][DATA_W-n];
            else
               m_sd[i] = 1'b0;
         end
      end
      m_fs = fs;
      m_ur = fs && !m_full && m_armed;
      if (m_ur && m_ucnt < 255) m_ucnt++;
      if (fs) begin
         if (m_full) begin
            for (int i = 0; i < 2; i++) begin
               m_tx_l[i] = m_buf_l; m_tx_r[i] = m_buf_r;
            end
         end else begin
            m_tx_l[0] = '0; m_tx_r[0] = '0;
            if (!m_armed) begin m_tx_l[1] = '0; m_tx_r[1] = '0; end
         end
         m_armed = 1'b1;
      end
      acc    = in_valid && !m_full;
      m_full = (m_full && !fs) || acc;
      if (acc) begin m_buf_l = in_left; m_buf_r = in_right; end
      m_acc      = acc;
      m_prev_rst = 1'b0;
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("in_ready%0d@%0d", i, cnt), in_ready[i], !m_full);
         chk($sformatf("frame_start%0d@%0d", i, cnt), frame_start[i], m_fs);
         chk($sformatf("underrun%0d@%0d", i, cnt), underrun[i], m_ur);
         chk($sformatf("sdout%0d@%0d", i, cnt), sdout[i], m_sd[i]);
`ifdef I2S_XMIT_UNDERRUN_CNT_EN
         chk($sformatf("ucnt%0d@%0d", i, cnt), ucnt[i], m_ucnt);
`endif
      end
      if (underrun[0] === 1'b1) ur_seen++;
   endtask

   task automatic tick();
      @(negedge mck);
      cnt  = cnt + 1;
      bck  = cnt[0];
      lrck = cnt[6];
      @(posedge mck);
      #1;
      model_step();
      check_all();
   endtask

   task automatic run_to(input int frames_ahead, input int off);
      int target;
      target = (cnt / FRAME + frames_ahead) * FRAME + off;
      while (cnt < target) tick();
   endtask

   task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
      int guard = 0;
      in_left = l; in_right = r; in_valid = 1'b1;
      do begin tick(); guard++; end while (!m_acc && guard < 400);
      in_valid = 1'b0;
      n_cmp++;
      assert (m_acc) else begin
         n_err++;
         $error("FAIL send_timeout: observed no accept expected accept within 400 cycles");
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, k;
      logic [DATA_W-1:0] pl [5];
      logic [DATA_W-1:0] pr [5];
      logic [DATA_W-1:0] p;

      // reset state, then three idle frames
      repeat (3) tick();
      reset = 1'b1;
      run_to(3, 10);
      chk("t1_underrun_count", ur_seen, 2);

      // directed pattern pair, then random pairs at random offsets
      send(24'hA5A5A5, 24'h5A5A5A);
      run_to(2, 10);
      for (int j = 0; j < 4; j++) begin
         repeat ($urandom_range(0, 100)) tick();
         send(DATA_W'($urandom), DATA_W'($urandom));
         run_to(1, 6);
      end

      // back-to-back pairs with in_valid held high
      pl[0] = 24'h800000; pr[0] = 24'h000001;
      for (int j = 1; j < 5; j++) begin
         pl[j] = DATA_W'($urandom); pr[j] = DATA_W'($urandom);
      end
      run_to(1, 4);
      base = ur_seen;
      k = 0;
      in_left = pl[0]; in_right = pr[0]; in_valid = 1'b1;
      for (int g = 0; g < 10 * FRAME && k < 5; g++) begin
         tick();
         if (m_acc) begin
            k++;
            if (k < 5) begin in_left = pl[k]; in_right = pr[k]; end
         end
      end
      in_valid = 1'b0;
      chk("t3_pairs_accepted", k, 5);
      run_to(1, 4);
      chk("t3_no_underrun", ur_seen - base, 0);

      // hold vs. silence on starvation
      send(24'h123456, 24'hABCDEF);
      run_to(4, 4);

      // reset in the middle of the left channel, with a pair buffered
      p = DATA_W'($urandom);
      p[DATA_W-10] = 1'b1;
      send(p, DATA_W'($urandom));
      run_to(1, 2);
      send(DATA_W'($urandom), DATA_W'($urandom));
      while (cnt % FRAME != 20) tick();
      chk("t5_pre_reset_sdout", sdout[0], 1'b1);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("t5_rst_sdout%0d", i), sdout[i], 1'b0);
         chk($sformatf("t5_rst_in_ready%0d", i), in_ready[i], 1'b1);
      end
      tick();
      tick();
      reset = 1'b1;
      base = ur_seen;
      run_to(1, 4);
      chk("t5_silent_no_underrun", ur_seen - base, 0);
      run_to(1, 4);
      chk("t5_underrun_after", ur_seen - base, 1);

`ifdef I2S_XMIT_UNDERRUN_CNT_EN
      // long starvation saturates the counter; reset clears it
      run_to(300, 4);
      chk("t6_ucnt_sat", ucnt[0], 8'hFF);
      chk("t6_ucnt_sat_hold", ucnt[1], 8'hFF);
      reset = 1'b0;
      #1;
      chk("t6_ucnt_rst", ucnt[0], 8'h00);
      tick();
      reset = 1'b1;
      run_to(1, 4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
